data_in32: RTL

Input packing stage for the 256-bit datapath. Accepts 32-bit words over a valid/ready handshake and assembles them into one 256-bit block. Presents the block as `PDI` with its own valid/ready handshake, and drives the `PDI` input of the `data_out32` stage directly downstream. Supports short final blocks via a last-word marker; unused words are zero-padded.

---
 rtl/data_in32_pkg.sv | 13 +
 rtl/data_in32.sv | 82 ++++++++
 2 files changed

// File: rtl/data_in32_pkg.sv
// Shared constants and FSM state type for the 32-bit to 256-bit input packer.
package data_in32_pkg;

  localparam int WORD_W = 32;
  localparam int NWORDS = 8;
  localparam int BLK_W  = 256;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

endpackage

// File: rtl/data_in32.sv
// Packs WORD_W-bit words into one WORD_W*NWORDS block; a short block ends on DI_last.
// Unused words are left zero.
module data_in32
  import data_in32_pkg::*;
#(
  parameter int WORD_W = data_in32_pkg::WORD_W,
  parameter int NWORDS = data_in32_pkg::NWORDS
) (
  input  logic                       CLK,
  input  logic                       rst,
  input  logic [WORD_W-1:0]          DI,
  input  logic                       DI_valid,
  input  logic                       DI_last,
  output logic                       DI_ready,
  output logic [WORD_W*NWORDS-1:0]   PDI,
  output logic                       PDI_valid,
  input  logic                       PDI_ready,
  output logic [$clog2(NWORDS+1)-1:0] PDI_nwords
);

  localparam int CNT_W = $clog2(NWORDS);
  localparam int NW_W  = $clog2(NWORDS+1);

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           wcnt_q, wcnt_d;
  logic [WORD_W*NWORDS-1:0]   pdi_q, pdi_d;
  logic [NW_W-1:0]            nwords_q, nwords_d;
  logic                       accept;

  assign DI_ready   = (state_q == FILL) & ~rst;
  assign PDI_valid  = (state_q == FULL);
  assign PDI        = pdi_q;
  assign PDI_nwords = nwords_q;
  assign accept     = DI_valid & DI_ready;

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    pdi_d    = pdi_q;
    nwords_d = nwords_q;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          for (int k = 0; k < NWORDS; k++) begin
            if (wcnt_q == CNT_W'(k)) pdi_d[k*WORD_W +: WORD_W] = DI;
          end
          if (wcnt_q == CNT_W'(NWORDS-1) || DI_last) begin
            state_d  = FULL;
            nwords_d = NW_W'(wcnt_q) + NW_W'(1);
            wcnt_d   = '0;
          end else begin
            wcnt_d = wcnt_q + CNT_W'(1);
          end
        end
      end
      FULL: begin
        // Clearing on delivery is what zero-pads the next short block.
        if (PDI_ready) begin
          state_d  = FILL;
          pdi_d    = '0;
          nwords_d = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q  <= FILL;
      wcnt_q   <= '0;
      pdi_q    <= '0;
      nwords_q <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      pdi_q    <= pdi_d;
      nwords_q <= nwords_d;
    end
  end

endmodule
